// File: rtl/stepper_seq_driver.sv
// 4-coil unipolar stepper sequencer: wave / full / half step, counted or continuous moves.
// Optional holding torque in IDLE when STEP_HOLD_EN is defined.
module stepper_seq_driver #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic [DIV_W-1:0] step_period,
  input  logic [CNT_W-1:0] step_count,
  input  logic             start,
  input  logic             run_en,
  input  logic             stop,
  output logic [3:0]       coils,
  output logic [2:0]       phase,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | waiting for start or run_en; coils off (or held with STEP_HOLD_EN)
  // MOVE  | counted move, remaining steps in rem_q
  // CONT  | continuous stepping while run_en stays high
  typedef enum logic [1:0] {IDLE, MOVE, CONT} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [2:0]       phase_q, phase_d;
  logic             done_q, done_d;
  logic [3:0]       coils_q, coils_d;
  logic             tick;
  logic             active;

  function automatic logic [3:0] coil_tbl(input logic [2:0] idx);
    logic [3:0] c;
    case (idx)
      3'd0:    c = 4'b0001;
      3'd1:    c = 4'b0011;
      3'd2:    c = 4'b0010;
      3'd3:    c = 4'b0110;
      3'd4:    c = 4'b0100;
      3'd5:    c = 4'b1100;
      3'd6:    c = 4'b1000;
      default: c = 4'b1001;
    endcase
    return c;
  endfunction

  // Wave stays on even indices, full on odd; off-grid indices snap in the step direction.
  function automatic logic [2:0] next_phase(input logic [2:0] idx, input logic [1:0] md,
                                            input logic fwd);
    logic [2:0] n;
    case (md)
      2'b00:   n = fwd ? ((idx | 3'd1) + 3'd1) : ((idx - 3'd1) & 3'b110);
      2'b10:   n = fwd ? (idx + 3'd1) : (idx - 3'd1);
      default: n = fwd ? ((idx + 3'd1) | 3'd1) : ((idx - 3'd2) | 3'd1);
    endcase
    return n;
  endfunction

  assign tick   = (presc_q == period_q);
  assign active = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    period_d = period_q;
    rem_d    = rem_q;
    phase_d  = phase_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (step_count != '0) begin
            state_d  = MOVE;
            rem_d    = step_count;
            presc_d  = '0;
            period_d = step_period;
          end else begin
            done_d = 1'b1;
          end
        end else if (run_en) begin
          state_d  = CONT;
          presc_d  = '0;
          period_d = step_period;
        end
      end
      MOVE: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          presc_d = tick ? '0 : presc_q + DIV_W'(1);
          if (tick) begin
            phase_d = next_phase(phase_q, mode, dir);
            rem_d   = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      CONT: begin
        // A tick coinciding with run_en falling is dropped.
        if (stop || !run_en) begin
          state_d = IDLE;
        end else begin
          presc_d = tick ? '0 : presc_q + DIV_W'(1);
          if (tick) phase_d = next_phase(phase_q, mode, dir);
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef STEP_HOLD_EN
  // Holding torque only once the motor has been driven since reset.
  logic armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed_q <= 1'b0;
    else if (active) armed_q <= 1'b1;
  end

  always_comb begin
    coils_d = 4'b0000;
    if (active || armed_q) coils_d = coil_tbl(phase_q);
  end
`else
  always_comb begin
    coils_d = 4'b0000;
    if (active) coils_d = coil_tbl(phase_q);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      period_q <= '0;
      rem_q    <= '0;
      phase_q  <= 3'd0;
      done_q   <= 1'b0;
      coils_q  <= 4'b0000;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      period_q <= period_d;
      rem_q    <= rem_d;
      phase_q  <= phase_d;
      done_q   <= done_d;
      coils_q  <= coils_d;
    end
  end

  assign coils = coils_q;
  assign phase = phase_q;
  assign busy  = active;
  assign done  = done_q;

endmodule

// File: tb/tb_stepper_seq_driver.sv
// Scoreboard bench for stepper_seq_driver: expected coil/phase/done events are queued
// as stimulus is applied and consumed by a monitor as the outputs change.
module tb_stepper_seq_driver;

`ifdef STEP_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic        dir = 1'b1;
  logic [15:0] step_period = '0;
  logic [15:0] step_count = '0;
  logic        start = 1'b0;
  logic        run_en = 1'b0;
  logic        stop = 1'b0;
  logic [3:0]  coils;
  logic [2:0]  phase;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] exp_coils[$];
  logic [2:0] exp_phase[$];
  bit         exp_done[$];
  logic [3:0] exp_last = 4'b0000;
  bit         armed = 1'b0;
  logic [3:0] coils_prev = 4'b0000;
  logic [2:0] phase_prev = 3'd0;

  stepper_seq_driver #(.DIV_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .dir(dir), .step_period(step_period),
    .step_count(step_count), .start(start), .run_en(run_en), .stop(stop),
    .coils(coils), .phase(phase), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] coil_of(input logic [2:0] p);
    case (p)
      3'd0: return 4'b0001;
      3'd1: return 4'b0011;
      3'd2: return 4'b0010;
      3'd3: return 4'b0110;
      3'd4: return 4'b0100;
      3'd5: return 4'b1100;
      3'd6: return 4'b1000;
      default: return 4'b1001;
    endcase
  endfunction

  function automatic logic [3:0] idle_c(input logic [2:0] p);
    return (HOLD && armed) ? coil_of(p) : 4'b0000;
  endfunction

  task automatic push_coil(input logic [3:0] v);
    if (v != exp_last) begin
      exp_coils.push_back(v);
      exp_last = v;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] cnt);
    start = 1'b1;
    step_count = cnt;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max, output int n);
    n = 0;
    while (busy && n < max) begin
      cyc(1);
      n++;
    end
  endtask

  task automatic drain(input string tag);
    cyc(3);
    chk({tag, "_coils_left"}, exp_coils.size(), 0);
    chk({tag, "_phase_left"}, exp_phase.size(), 0);
    chk({tag, "_done_left"}, exp_done.size(), 0);
  endtask

  always @(negedge clk) begin
    if (coils !== coils_prev) begin
      if (exp_coils.size() == 0) chk("coils_qlen", exp_coils.size(), 1);
      else chk("coils", coils, exp_coils.pop_front());
      coils_prev = coils;
    end
    if (phase !== phase_prev) begin
      if (exp_phase.size() == 0) chk("phase_qlen", exp_phase.size(), 1);
      else chk("phase", phase, exp_phase.pop_front());
      phase_prev = phase;
    end
    if (done) begin
      if (exp_done.size() == 0) chk("done_qlen", exp_done.size(), 1);
      else begin
        void'(exp_done.pop_front());
        chk("done_busy", busy, 0);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [2:0] p;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_coils", coils, 0);
    chk("rst_phase", phase, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(1);

    // half-step forward, 8 counted steps, 4 clocks each
    mode = 2'b10; dir = 1'b1; step_period = 16'd3;
    armed = 1'b1;
    for (int i = 0; i < 8; i++) push_coil(coil_of(3'(i)));
    for (int i = 1; i <= 8; i++) exp_phase.push_back(3'(i));
    push_coil(idle_c(3'd0));
    exp_done.push_back(1'b1);
    pulse_start(16'd8);
    wait_idle(100, n);
    chk("t1_busy_len", n, 32);
    chk("t1_phase", phase, 0);
    drain("t1");

    // wave reverse, continuous, period 0
    mode = 2'b00; dir = 1'b0; step_period = 16'd0;
    push_coil(coil_of(3'd0));
    p = 3'd0;
    for (int i = 0; i < 5; i++) begin
      p = (p - 3'd1) & 3'b110;
      exp_phase.push_back(p);
      push_coil(coil_of(p));
    end
    push_coil(idle_c(3'd6));
    run_en = 1'b1;
    repeat (6) @(posedge clk);
    #1 run_en = 1'b0;
    chk("t2_busy_hold", busy, 1);
    cyc(1);
    chk("t2_busy_drop", busy, 0);
    chk("t2_phase", phase, 6);
    drain("t2");

    // zero-length counted move
    exp_done.push_back(1'b1);
    pulse_start(16'd0);
    chk("t3_done", done, 1);
    chk("t3_busy", busy, 0);
    cyc(1);
    chk("t3_done_low", done, 0);
    chk("t3_busy_low", busy, 0);
    chk("t3_phase", phase, 6);
    drain("t3");

    // long move aborted by stop on a tick edge; start while busy ignored
    mode = 2'b10; dir = 1'b1; step_period = 16'd1;
    push_coil(coil_of(3'd6));
    p = 3'd6;
    for (int i = 0; i < 10; i++) begin
      p = p + 3'd1;
      exp_phase.push_back(p);
      push_coil(coil_of(p));
    end
    push_coil(idle_c(3'd0));
    pulse_start(16'd100);
    cyc(5);
    start = 1'b1; step_count = 16'd3;
    cyc(1);
    start = 1'b0; step_count = 16'd100;
    cyc(15);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_phase", phase, 0);
    cyc(10);
    chk("t4_phase_frozen", phase, 0);
    drain("t4");

    // reach phase 2 by half steps, then full-step forward snaps to 3
    mode = 2'b10; dir = 1'b1; step_period = 16'd0;
    push_coil(coil_of(3'd0));
    exp_phase.push_back(3'd1); exp_phase.push_back(3'd2);
    push_coil(coil_of(3'd1));
    push_coil(idle_c(3'd2));
    exp_done.push_back(1'b1);
    pulse_start(16'd2);
    wait_idle(50, n);
    chk("t5a_len", n, 2);
    drain("t5a");

    mode = 2'b01;
    push_coil(coil_of(3'd2));
    exp_phase.push_back(3'd3); push_coil(coil_of(3'd3));
    exp_phase.push_back(3'd5); push_coil(coil_of(3'd5));
    exp_phase.push_back(3'd7); push_coil(coil_of(3'd7));
    exp_phase.push_back(3'd1);
    push_coil(idle_c(3'd1));
    exp_done.push_back(1'b1);
    pulse_start(16'd4);
    wait_idle(50, n);
    chk("t5b_len", n, 4);
    chk("t5b_phase", phase, 1);
    drain("t5b");

    // mode 11 behaves as full-step, reverse
    mode = 2'b11; dir = 1'b0;
    push_coil(coil_of(3'd1));
    exp_phase.push_back(3'd7); push_coil(coil_of(3'd7));
    exp_phase.push_back(3'd5);
    push_coil(idle_c(3'd5));
    exp_done.push_back(1'b1);
    pulse_start(16'd2);
    wait_idle(50, n);
    chk("t5c_len", n, 2);
    chk("t5c_phase", phase, 5);
    drain("t5c");

    // asynchronous reset in the middle of a move
    mode = 2'b10; dir = 1'b1; step_period = 16'd2;
    push_coil(coil_of(3'd5));
    exp_phase.push_back(3'd6); push_coil(coil_of(3'd6));
    exp_phase.push_back(3'd7); push_coil(coil_of(3'd7));
    exp_phase.push_back(3'd0);
    push_coil(4'b0000);
    armed = 1'b0;
    pulse_start(16'd100);
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_coils", coils, 0);
    chk("t6_busy", busy, 0);
    chk("t6_phase", phase, 0);
    chk("t6_done", done, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(3);
    chk("t6_idle_coils", coils, 0);
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
